sqrt_odd_seq: RTL and testbench
===============================

Name: sqrt_odd_seq

Overview:
Parametrised, multi-cycle integer square root using the odd-number subtraction method (n² = 1+3+5+…+(2n−1)). It is the sequential successor to our combinational 8-bit odd-subtraction square root. It accepts a WIDTH-bit unsigned operand on a start pulse and iterates one subtraction per clock. It returns floor(sqrt(I)) and the remainder I − O², with a busy/done handshake, for use by datapath blocks that cannot afford a wide combinational chain.

Parameters:
WIDTH, 16, operand width in bits; must be even and ≥4 (elaboration error otherwise)
OUT_W, WIDTH/2, root width; derived, not to be overridden

Ports:
clk  input  1  clock, rising-edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only when busy=0
I  input  WIDTH  unsigned operand; captured on accepted start
busy  output  1  high while a computation is in progress or done is shown
done  output  1  one-cycle pulse: O/R valid and newly updated
O  output  OUT_W  floor(sqrt(I)), registered, held until next result
R  output  OUT_W+1  remainder I − O², registered, held until next result

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE; O=0, R=0, busy=0, done=0; internal rem/odd/cnt cleared. Reset wins over every other input, including mid-computation; any in-flight result is discarded.
- Internal registers:
  - rem: WIDTH bits.
  - odd: OUT_W+1 bits, max value 2^(OUT_W+1)−1.
  - cnt: OUT_W bits.
  - Comparison rem ≥ odd uses zero-extension of odd to WIDTH bits.
- States: IDLE, CALC, DONE.
- IDLE: busy=0, done=0. Edge with start=1: rem←I, odd←1, cnt←0, go CALC. With start=0, stay in IDLE.
- CALC: busy=1.
  - Each edge with rem ≥ odd: rem←rem−odd, odd←odd+2, cnt←cnt+1, stay in CALC.
  - Edge with rem < odd: O←cnt, R←rem[OUT_W:0], go DONE.
- DONE: busy=1, done=1 for exactly one cycle; next edge returns to IDLE unconditionally.
- Latency: if the start is accepted at edge E0, done is high in the cycle after edge E0+s+1, where s=floor(sqrt(I)).
  - I=0 gives done after E1.
  - Worst case (I=2^WIDTH−1) gives s+1 = 2^OUT_W edges; 256 for WIDTH=16.
- Next start can be accepted earliest in the cycle after done (back-to-back: one idle cycle between operations).
- start while busy=1 (CALC or DONE) is ignored and not queued.
- I is don't-care except at the accepting edge; changes during CALC have no effect.
- O and R change only on the CALC→DONE edge or on reset; they hold across IDLE.
- Width safety: cnt never exceeds 2^OUT_W−1, and odd never exceeds 2·(2^OUT_W−1)+1. No wrap-around is permitted or possible for legal WIDTH; R ≤ 2·O fits in OUT_W+1 bits.
- Outputs are driven directly from registers or from state decode only; no combinational path from inputs to outputs.

Test Plan:
- Reset: assert rst for 2 cycles during an active CALC (I=65535) → next cycle busy=0, done=0, O=0, R=0; a subsequent start with I=9 gives O=3, R=0.
- Directed values (WIDTH=16), each run to done:
  - I=0 → O=0, R=0, done 1 edge after start.
  - I=4 → O=2, R=0.
  - I=56 → O=7, R=7.
  - I=156 → O=12, R=12.
  - I=135 → O=11, R=14.
  - I=223 → O=14, R=27.
  - Check done arrives exactly s+1 edges after the start edge.
- Max operand: I=65535 → O=255, R=510, done 256 edges after start; busy high throughout; single-cycle done.
- Handshake abuse:
  - Hold start=1 continuously with changing I → only the operands sampled in IDLE are computed; results match those I values.
  - start pulses in CALC/DONE → ignored.
  - Changing I during CALC → result unchanged.
- Parameter sweep: WIDTH=8, exhaustive I=0..255 against a reference model. Check O=floor(sqrt(I)), R=I−O², latency=O+1 edges, and O/R stable between done pulses.

Source files
------------

// File: rtl/sqrt_odd_seq_if.sv
// Operand/result handshake bundle for the sequential
// odd-subtraction square root.
interface sqrt_odd_seq_if #(
  parameter int WIDTH = 16
);
  localparam int OUT_W = WIDTH / 2;

  logic             start;
  logic [WIDTH-1:0] I;
  logic             busy;
  logic             done;
  logic [OUT_W-1:0] O;
  logic [OUT_W:0]   R;

  modport master (
    output start, I,
    input  busy, done, O, R
  );

  modport slave (
    input  start, I,
    output busy, done, O, R
  );
endinterface

// File: rtl/sqrt_odd_seq.sv
// Multi-cycle integer square root by repeated subtraction of
// successive odd numbers; one subtraction per clock.
module sqrt_odd_seq #(
  parameter int WIDTH = 16,
  localparam int OUT_W = WIDTH / 2
) (
  input  logic           clk,
  input  logic           rst,
  sqrt_odd_seq_if.slave  bus
);

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("sqrt_odd_seq: WIDTH must be even and >= 4");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [OUT_W:0]   odd_q, odd_d;
  logic [OUT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] o_q, o_d;
  logic [OUT_W:0]   r_q, r_d;

  logic [WIDTH-1:0] odd_ext;
  logic             ge;

  assign odd_ext = {{(WIDTH-OUT_W-1){1'b0}}, odd_q};
  assign ge      = rem_q >= odd_ext;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    odd_d   = odd_q;
    cnt_d   = cnt_q;
    o_d     = o_q;
    r_d     = r_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          rem_d   = bus.I;
          odd_d   = {{OUT_W{1'b0}}, 1'b1};
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (ge) begin
          rem_d = rem_q - odd_ext;
          odd_d = odd_q + {{(OUT_W-1){1'b0}}, 2'd2};
          cnt_d = cnt_q + {{(OUT_W-1){1'b0}}, 1'b1};
        end else begin
          o_d     = cnt_q;
          r_d     = rem_q[OUT_W:0];
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      odd_q   <= '0;
      cnt_q   <= '0;
      o_q     <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      odd_q   <= odd_d;
      cnt_q   <= cnt_d;
      o_q     <= o_d;
      r_q     <= r_d;
    end
  end

  assign bus.busy = state_q != S_IDLE;
  assign bus.done = state_q == S_DONE;
  assign bus.O    = o_q;
  assign bus.R    = r_q;

endmodule

// File: tb/tb_sqrt_odd_seq.sv
// Bench for sqrt_odd_seq: directed table, reset abort, max operand,
// handshake abuse, random 16-bit and exhaustive 8-bit operands.
module tb_sqrt_odd_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  sqrt_odd_seq_if #(.WIDTH(16)) b16 ();
  sqrt_odd_seq_if #(.WIDTH(8))  b8 ();

  sqrt_odd_seq #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .bus(b16));
  sqrt_odd_seq #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(b8));

  typedef struct {
    int i;
    int o;
    int r;
  } vec_t;

  vec_t tbl[7];
  int   q[$];

  function automatic int isqrt(input int v);
    int s = 0;
    while ((s + 1) * (s + 1) <= v) s++;
    return s;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Start one op on the selected DUT and follow it to done.
  task automatic run(input bit sm, input int val,
                     output int lat, output int o, output int r,
                     output bit bsy_ok, output bit one_ok, output bit hold_ok);
    @(negedge clk);
    if (sm) begin b8.start = 1'b1; b8.I = val[7:0]; end
    else begin b16.start = 1'b1; b16.I = val[15:0]; end
    @(posedge clk); #1;
    b8.start = 1'b0; b16.start = 1'b0;
    b8.I = 8'($urandom); b16.I = 16'($urandom);
    lat = 0; o = -1; r = -1; bsy_ok = 1'b1;
    while (lat < 400) begin
      @(negedge clk);
      if (sm ? b8.done : b16.done) begin
        o = sm ? int'(b8.O) : int'(b16.O);
        r = sm ? int'(b8.R) : int'(b16.R);
        break;
      end
      if (!(sm ? b8.busy : b16.busy)) bsy_ok = 1'b0;
      if (sm) b8.I = 8'($urandom); else b16.I = 16'($urandom);
      if (sm) b8.start = 1'b1; else b16.start = 1'b1;
      @(posedge clk); #1;
      b8.start = 1'b0; b16.start = 1'b0;
      lat++;
    end
    @(negedge clk);
    one_ok  = sm ? (!b8.done && !b8.busy) : (!b16.done && !b16.busy);
    hold_ok = sm ? (int'(b8.O) == o && int'(b8.R) == r)
                 : (int'(b16.O) == o && int'(b16.R) == r);
  endtask

  initial begin
    int lat, o, r, s, v;
    bit bk, ok1, okh;

    b16.start = 1'b0; b16.I = '0;
    b8.start  = 1'b0; b8.I  = '0;

    tbl[0] = '{0, 0, 0};
    tbl[1] = '{4, 2, 0};
    tbl[2] = '{56, 7, 7};
    tbl[3] = '{156, 12, 12};
    tbl[4] = '{135, 11, 14};
    tbl[5] = '{223, 14, 27};
    tbl[6] = '{9, 3, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", b16.busy, 0);
    chk("rst_done", b16.done, 0);
    chk("rst_O", b16.O, 0);
    chk("rst_R", b16.R, 0);
    rst = 1'b0;

    for (int k = 0; k < 6; k++) begin
      run(1'b0, tbl[k].i, lat, o, r, bk, ok1, okh);
      chk($sformatf("dir_O[%0d]", tbl[k].i), o, tbl[k].o);
      chk($sformatf("dir_R[%0d]", tbl[k].i), r, tbl[k].r);
      chk($sformatf("dir_lat[%0d]", tbl[k].i), lat, tbl[k].o + 1);
      chk($sformatf("dir_busy[%0d]", tbl[k].i), bk, 1);
      chk($sformatf("dir_1cyc[%0d]", tbl[k].i), ok1, 1);
    end

    // Reset in the middle of a long computation.
    @(negedge clk);
    b16.start = 1'b1; b16.I = 16'hFFFF;
    @(posedge clk); #1;
    b16.start = 1'b0;
    repeat (20) @(negedge clk);
    chk("pre_rst_busy", b16.busy, 1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("abort_busy", b16.busy, 0);
    chk("abort_done", b16.done, 0);
    chk("abort_O", b16.O, 0);
    chk("abort_R", b16.R, 0);
    rst = 1'b0;
    run(1'b0, tbl[6].i, lat, o, r, bk, ok1, okh);
    chk("after_rst_O", o, tbl[6].o);
    chk("after_rst_R", r, tbl[6].r);

    run(1'b0, 65535, lat, o, r, bk, ok1, okh);
    chk("max_O", o, 255);
    chk("max_R", r, 510);
    chk("max_lat", lat, 256);
    chk("max_busy", bk, 1);
    chk("max_1cyc", ok1, 1);
    chk("max_hold", okh, 1);

    // start held high with I changing every cycle.
    q.delete();
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      if (b16.done) begin
        if (q.size() == 0) chk("abuse_spurious", 1, 0);
        else begin
          v = q.pop_front();
          s = isqrt(v);
          chk("abuse_O", b16.O, s);
          chk("abuse_R", b16.R, v - s * s);
        end
      end
      b16.I = 16'($urandom_range(0, 3000));
      b16.start = 1'b1;
      if (!b16.busy) q.push_back(int'(b16.I));
    end
    @(posedge clk); #1;
    b16.start = 1'b0;
    for (int c = 0; c < 200 && q.size() > 0; c++) begin
      @(negedge clk);
      if (b16.done) begin
        v = q.pop_front();
        s = isqrt(v);
        chk("drain_O", b16.O, s);
        chk("drain_R", b16.R, v - s * s);
      end
    end
    chk("abuse_queue_empty", q.size(), 0);

    for (int k = 0; k < 30; k++) begin
      v = int'($urandom_range(0, 65535));
      s = isqrt(v);
      run(1'b0, v, lat, o, r, bk, ok1, okh);
      chk($sformatf("rnd_O[%0d]", v), o, s);
      chk($sformatf("rnd_R[%0d]", v), r, v - s * s);
      chk($sformatf("rnd_lat[%0d]", v), lat, s + 1);
    end

    for (int k = 0; k < 256; k++) begin
      s = isqrt(k);
      run(1'b1, k, lat, o, r, bk, ok1, okh);
      chk($sformatf("w8_O[%0d]", k), o, s);
      chk($sformatf("w8_R[%0d]", k), r, k - s * s);
      chk($sformatf("w8_lat[%0d]", k), lat, s + 1);
      chk($sformatf("w8_hold[%0d]", k), okh, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
